// File: rtl/reg_bank_sb_pkg.sv
// Shared defaults and types for the bypassing register bank with busy scoreboard.
package reg_bank_sb_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_PC_IDX = 7;
  localparam int DEF_NREG   = 2 ** DEF_ADDR_W;

  typedef logic [DEF_ADDR_W-1:0] regAddr_t;
endpackage

// File: rtl/reg_bank_sb_if.sv
// Register-bank access bundle: write ports, read ports, reservation and status outputs.
// There is no valid/ready pairing here: every enable is a single-cycle qualifier
// sampled at the rising edge, and every output is a zero-latency combinational result.
interface reg_bank_sb_if
  import reg_bank_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] in;
  logic              write;
  logic [ADDR_W-1:0] writeAdd;
  logic [DATA_W-1:0] inR7;
  logic              writeR7;
  logic [ADDR_W-1:0] readAdd1;
  logic [ADDR_W-1:0] readAdd2;
  logic              rdEn1;
  logic              rdEn2;
  logic              reserve;
  logic [ADDR_W-1:0] reserveAdd;
  logic [DATA_W-1:0] regValue1;
  logic [DATA_W-1:0] regValue2;
  logic              equalValue;
  logic [DATA_W-1:0] pcValue;
  logic              hazard;
  logic [NREG-1:0]   busyVec;

  modport master (
    output in, write, writeAdd, inR7, writeR7, readAdd1, readAdd2,
           rdEn1, rdEn2, reserve, reserveAdd,
    input  regValue1, regValue2, equalValue, pcValue, hazard, busyVec
  );

  modport slave (
    input  in, write, writeAdd, inR7, writeR7, readAdd1, readAdd2,
           rdEn1, rdEn2, reserve, reserveAdd,
    output regValue1, regValue2, equalValue, pcValue, hazard, busyVec
  );
endinterface

// File: rtl/reg_bank_sb_bypass_mux.sv
// One read port: selects forwarded write data, forwarded PC-port data or the stored value,
// and reports whether the addressed register is still waiting on its producer.
module reg_bypass_mux
  import reg_bank_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PC_IDX = DEF_PC_IDX,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              busy,
  input  logic              write,
  input  logic [ADDR_W-1:0] write_add,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_pc,
  input  logic [DATA_W-1:0] pc_data,
  output logic [DATA_W-1:0] value,
  output logic              pend
);
  localparam logic              EN      = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic hit_w;
  logic hit_pc;

  assign hit_w  = EN && write && (write_add == addr);
  assign hit_pc = EN && write_pc && (addr == PC_ADDR);

  // General write has priority, matching which write lands in the array on a PC collision.
  always_comb begin
    value = stored;
    if (hit_w)       value = write_data;
    else if (hit_pc) value = pc_data;
  end

  // Only a general write retires the producer; the PC port never clears busy.
  assign pend = busy && !hit_w;
endmodule

// File: rtl/reg_bank_sb.sv
// Decode-stage register bank: two bypassed read ports, general and PC write ports,
// branch-equality compare and a per-register busy scoreboard driving the stall signal.
module reg_bank_sb
  import reg_bank_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PC_IDX = DEF_PC_IDX,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset,
  reg_bank_sb_if.slave  bus
);
  localparam int                NREG    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  logic              pend1;
  logic              pend2;

  // Reserve is applied after the clear so a same-cycle new producer keeps the bit set.
  always_comb begin
    busy_nxt = busy;
    if (bus.write)   busy_nxt[bus.writeAdd]   = 1'b0;
    if (bus.reserve) busy_nxt[bus.reserveAdd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      if (bus.write) regs[bus.writeAdd] <= bus.in;
      if (bus.writeR7 && !(bus.write && (bus.writeAdd == PC_ADDR))) regs[PC_ADDR] <= bus.inR7;
    end
  end

  reg_bypass_mux #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_IDX(PC_IDX), .BYPASS(BYPASS)
  ) u_rd1 (
    .addr(bus.readAdd1), .stored(regs[bus.readAdd1]), .busy(busy[bus.readAdd1]),
    .write(bus.write), .write_add(bus.writeAdd), .write_data(bus.in),
    .write_pc(bus.writeR7), .pc_data(bus.inR7),
    .value(val1), .pend(pend1)
  );

  reg_bypass_mux #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_IDX(PC_IDX), .BYPASS(BYPASS)
  ) u_rd2 (
    .addr(bus.readAdd2), .stored(regs[bus.readAdd2]), .busy(busy[bus.readAdd2]),
    .write(bus.write), .write_add(bus.writeAdd), .write_data(bus.in),
    .write_pc(bus.writeR7), .pc_data(bus.inR7),
    .value(val2), .pend(pend2)
  );

  assign bus.regValue1  = val1;
  assign bus.regValue2  = val2;
  assign bus.equalValue = (val1 == val2);
  assign bus.pcValue    = regs[PC_ADDR];
  assign bus.hazard     = (bus.rdEn1 && pend1) || (bus.rdEn2 && pend2);
  assign bus.busyVec    = busy;
endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed vector table for reg_bank_sb, run on a bypassing and a non-bypassing instance.
module tb_reg_bank_sb;
  import reg_bank_sb_pkg::*;

  typedef struct {
    logic        rst;
    logic        wr;
    regAddr_t    wa;
    logic [15:0] wd;
    logic        wp;
    logic [15:0] pd;
    regAddr_t    r1;
    regAddr_t    r2;
    logic        e1;
    logic        e2;
    logic        rs;
    regAddr_t    ra;
    logic [15:0] v1;
    logic [15:0] v2;
    logic        eq;
    logic [15:0] pc;
    logic        hz;
    logic [7:0]  busy;
    logic [15:0] nb1;
    logic        nbhz;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vt[$];

  reg_bank_sb_if #(.DATA_W(16), .ADDR_W(3)) bus_b ();
  reg_bank_sb_if #(.DATA_W(16), .ADDR_W(3)) bus_n ();

  reg_bank_sb #(.DATA_W(16), .ADDR_W(3), .PC_IDX(7), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );
  reg_bank_sb #(.DATA_W(16), .ADDR_W(3), .PC_IDX(7), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .bus(bus_n.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input vec_t v);
    vt.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    reset          = v.rst;
    bus_b.write    = v.wr;  bus_n.write    = v.wr;
    bus_b.writeAdd = v.wa;  bus_n.writeAdd = v.wa;
    bus_b.in       = v.wd;  bus_n.in       = v.wd;
    bus_b.writeR7  = v.wp;  bus_n.writeR7  = v.wp;
    bus_b.inR7     = v.pd;  bus_n.inR7     = v.pd;
    bus_b.readAdd1 = v.r1;  bus_n.readAdd1 = v.r1;
    bus_b.readAdd2 = v.r2;  bus_n.readAdd2 = v.r2;
    bus_b.rdEn1    = v.e1;  bus_n.rdEn1    = v.e1;
    bus_b.rdEn2    = v.e2;  bus_n.rdEn2    = v.e2;
    bus_b.reserve  = v.rs;  bus_n.reserve  = v.rs;
    bus_b.reserveAdd = v.ra; bus_n.reserveAdd = v.ra;
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    vec_t idle;
    total = 0;
    bad   = 0;
    idle  = '{1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0,
              16'h0, 16'h0, 1'b1, 16'h0, 1'b0, 8'h00, 16'h0, 1'b0};

    //   rst   wr    wa    wd        wp    pd        r1    r2    e1    e2    rs    ra
    //   v1        v2        eq    pc        hz    busy   nb1       nbhz
    // reset state, then write R3 and reset over it
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0});
    add('{1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 16'h0000, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0});
    add('{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h1234, 1'b0});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0});
    // same-cycle bypass of R2
    add('{1'b0, 1'b1, 3'd2, 16'hBEEF, 1'b0, 16'h0000, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0,
          16'hBEEF, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0,
          16'hBEEF, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 16'hBEEF, 1'b0});
    // PC collision: general write wins, then PC port alone
    add('{1'b0, 1'b1, 3'd7, 16'h0100, 1'b1, 16'h0042, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h0100, 16'h0100, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd7, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h0100, 16'hBEEF, 1'b0, 16'h0100, 1'b0, 8'h00, 16'h0100, 1'b0});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0042, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h0042, 16'h0000, 1'b0, 16'h0100, 1'b0, 8'h00, 16'h0100, 1'b0});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd7, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h0042, 16'hBEEF, 1'b0, 16'h0042, 1'b0, 8'h00, 16'h0042, 1'b0});
    // equality, including a forwarded operand
    add('{1'b0, 1'b1, 3'd1, 16'h00FF, 1'b0, 16'h0000, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h00FF, 16'h00FF, 1'b1, 16'h0042, 1'b0, 8'h00, 16'h0000, 1'b0});
    add('{1'b0, 1'b1, 3'd2, 16'h00FF, 1'b0, 16'h0000, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h00FF, 16'h00FF, 1'b1, 16'h0042, 1'b0, 8'h00, 16'h00FF, 1'b0});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h00FF, 16'h00FF, 1'b1, 16'h0042, 1'b0, 8'h00, 16'h00FF, 1'b0});
    add('{1'b0, 1'b1, 3'd2, 16'h01FF, 1'b0, 16'h0000, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h00FF, 16'h01FF, 1'b0, 16'h0042, 1'b0, 8'h00, 16'h00FF, 1'b0});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h00FF, 16'h01FF, 1'b0, 16'h0042, 1'b0, 8'h00, 16'h00FF, 1'b0});
    // scoreboard on R5
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd5, 3'd0, 1'b1, 1'b0, 1'b1, 3'd5,
          16'h0000, 16'h0000, 1'b1, 16'h0042, 1'b0, 8'h00, 16'h0000, 1'b0});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0,
          16'h0000, 16'h0000, 1'b1, 16'h0042, 1'b1, 8'h20, 16'h0000, 1'b1});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h0000, 16'h0000, 1'b1, 16'h0042, 1'b0, 8'h20, 16'h0000, 1'b0});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd0, 3'd5, 1'b0, 1'b1, 1'b0, 3'd0,
          16'h0000, 16'h0000, 1'b1, 16'h0042, 1'b1, 8'h20, 16'h0000, 1'b1});
    add('{1'b0, 1'b1, 3'd5, 16'h0A0A, 1'b0, 16'h0000, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0,
          16'h0A0A, 16'h0000, 1'b0, 16'h0042, 1'b0, 8'h20, 16'h0000, 1'b1});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0,
          16'h0A0A, 16'h0000, 1'b0, 16'h0042, 1'b0, 8'h00, 16'h0A0A, 1'b0});
    // reserve and write R5 together: set wins
    add('{1'b0, 1'b1, 3'd5, 16'h1111, 1'b0, 16'h0000, 3'd5, 3'd0, 1'b1, 1'b0, 1'b1, 3'd5,
          16'h1111, 16'h0000, 1'b0, 16'h0042, 1'b0, 8'h00, 16'h0A0A, 1'b0});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0,
          16'h1111, 16'h0000, 1'b0, 16'h0042, 1'b1, 8'h20, 16'h1111, 1'b1});
    // re-reserve busy R5; clear of non-busy R3 is a no-op
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5,
          16'h0000, 16'h0000, 1'b1, 16'h0042, 1'b0, 8'h20, 16'h0000, 1'b0});
    add('{1'b0, 1'b1, 3'd3, 16'h0003, 1'b0, 16'h0000, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0,
          16'h0003, 16'h0000, 1'b0, 16'h0042, 1'b0, 8'h20, 16'h0000, 1'b0});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0,
          16'h0003, 16'h0000, 1'b0, 16'h0042, 1'b0, 8'h20, 16'h0003, 1'b0});
    // reset mid-operation: R4/R6 pending plus a write to R1 in flight
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4,
          16'h0000, 16'h0000, 1'b1, 16'h0042, 1'b0, 8'h20, 16'h0000, 1'b0});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6,
          16'h0000, 16'h0000, 1'b1, 16'h0042, 1'b0, 8'h30, 16'h0000, 1'b0});
    add('{1'b1, 1'b1, 3'd1, 16'hDEAD, 1'b0, 16'h0000, 3'd0, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0,
          16'h0000, 16'h0000, 1'b1, 16'h0042, 1'b1, 8'h70, 16'h0000, 1'b1});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd1, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0,
          16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0});
    // PC port never clears busy on R7
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd7, 3'd0, 1'b0, 1'b0, 1'b1, 3'd7,
          16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0009, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0,
          16'h0009, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h80, 16'h0000, 1'b1});
    add('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0,
          16'h0009, 16'h0000, 1'b0, 16'h0009, 1'b1, 8'h80, 16'h0009, 1'b1});

    // initial reset held over two edges
    apply(idle);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      apply(vt[i]);
      #1;
      check("regValue1",  i, 32'(bus_b.regValue1),  32'(vt[i].v1));
      check("regValue2",  i, 32'(bus_b.regValue2),  32'(vt[i].v2));
      check("equalValue", i, 32'(bus_b.equalValue), 32'(vt[i].eq));
      check("pcValue",    i, 32'(bus_b.pcValue),    32'(vt[i].pc));
      check("hazard",     i, 32'(bus_b.hazard),     32'(vt[i].hz));
      check("busyVec",    i, 32'(bus_b.busyVec),    32'(vt[i].busy));
      check("nb_regValue1", i, 32'(bus_n.regValue1), 32'(vt[i].nb1));
      check("nb_hazard",    i, 32'(bus_n.hazard),    32'(vt[i].nbhz));
      check("nb_busyVec",   i, 32'(bus_n.busyVec),   32'(vt[i].busy));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_bank_sb.md
Name: reg_bank_sb

Overview:
Parametrised successor of the 16-bit, 8-entry register bank. It provides two combinational read ports, one general write port and a dedicated PC-register write port. It adds write-to-read bypass, equality compare on the bypassed operands, a direct PC output, and a per-register busy scoreboard with hazard output. It sits in the decode/register-read stage and feeds operands, branch-equality and stall signals to the pipeline.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register address width; depth NREG = 2**ADDR_W
PC_IDX, 7, index of the register written by the dedicated PC port
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
in  in  DATA_W  general write data
write  in  1  general write enable
writeAdd  in  ADDR_W  general write address
inR7  in  DATA_W  PC-port write data
writeR7  in  1  PC-port write enable
readAdd1  in  ADDR_W  read port 1 address
readAdd2  in  ADDR_W  read port 2 address
rdEn1  in  1  port 1 operand is consumed (hazard qualification)
rdEn2  in  1  port 2 operand is consumed
reserve  in  1  mark reserveAdd as pending (instruction issued)
reserveAdd  in  ADDR_W  destination being reserved
regValue1  out  DATA_W  read data port 1
regValue2  out  DATA_W  read data port 2
equalValue  out  1  regValue1 == regValue2
pcValue  out  DATA_W  stored value of register PC_IDX (no bypass)
hazard  out  1  consumed operand is pending
busyVec  out  NREG  scoreboard bits, debug/verification visibility

Behaviour:
- Reset (reset=1 at posedge): all registers = 0, all busy bits = 0. Reset overrides every write/reserve in the same cycle. After reset, regValue1/2 = 0, pcValue = 0, equalValue = 1, hazard = 0, busyVec = 0.
- Write: at posedge, if write, reg[writeAdd] <= in. If writeR7 and not (write && writeAdd==PC_IDX), reg[PC_IDX] <= inR7. The general write wins a collision on PC_IDX.
- Read (combinational, zero latency), port n with address A:
  - BYPASS=1 and write && writeAdd==A -> in
  - else BYPASS=1 and writeR7 && A==PC_IDX -> inR7
  - else reg[A]
  - BYPASS=0 -> reg[A] only; new data is visible the cycle after the write.
- equalValue: full DATA_W compare of the final regValue1 and regValue2, including bypassed values.
- pcValue: always reg[PC_IDX] as stored; never bypassed.
- Scoreboard, at posedge:
  - write clears busy[writeAdd].
  - reserve sets busy[reserveAdd].
  - Same address set and cleared in one cycle -> set wins (new producer).
  - writeR7 never touches busy.
  - Reserving an already-busy register keeps it busy. Clearing a non-busy register is a no-op.
- hazard (combinational) = (rdEn1 && pend(readAdd1)) || (rdEn2 && pend(readAdd2)), where pend(A) = busy[A] && !(BYPASS && write && writeAdd==A). A write in the same cycle resolves the hazard only when BYPASS=1.
- Widths: all compares are unsigned equality; no arithmetic.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, PC_IDX constant, a regAddr_t typedef.
- One natural sub-module: reg_bypass_mux (one instance per read port: stored value, write/PC-write forwarding, pending flag).
- The equality compare stays inline.

Test Plan:
- Reset: write R3=0x1234 then assert reset -> all reads 0, busyVec=0, equalValue=1, hazard=0.
- Bypass: write=1, writeAdd=2, in=0xBEEF, readAdd1=2 in the same cycle -> regValue1=0xBEEF that cycle. With BYPASS=0 -> old value that cycle, 0xBEEF the next.
- PC collision: write=1 writeAdd=7 in=0x0100, writeR7=1 inR7=0x0042 -> next cycle pcValue=0x0100. writeR7 alone with inR7=0x0042 -> pcValue=0x0042 next cycle.
- Equality: R1=0x00FF, R2=0x00FF -> equalValue=1. Write R2=0x01FF forwarded in the same cycle -> equalValue=0 immediately.
- Scoreboard:
  - reserve R5, then readAdd1=5 rdEn1=1 -> hazard=1; with rdEn1=0 -> hazard=0.
  - write R5 -> hazard=0 in the same cycle (BYPASS=1) and busyVec[5]=0 after.
  - reserve R5 and write R5 in the same cycle -> busyVec[5]=1.
- Reset mid-operation: busy R4 and R6 pending plus a write in flight, assert reset -> busyVec=0 and write discarded.
